// File: rtl/demux3.sv
// demux3: registered 1-to-3 stream demux, packet-locked routing, 1-cycle latency, stalls hold o/o_valid.
// Optional DEMUX3_SKID_EN adds a one-beat skid so d_ready is a flop with no path from o_ready.
module demux3 #(
  parameter int WIREWIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         s,
  input  logic [WIREWIDTH:0] d,
  input  logic               d_valid,
  input  logic               d_last,
  output logic               d_ready,
  output logic [WIREWIDTH:0] o,
  output logic               o_last,
  output logic [2:0]         o_valid,
  input  logic [2:0]         o_ready,
  output logic               busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q;
  logic [1:0]         lch_q;

  logic               full_q, full_d;
  logic [WIREWIDTH:0] dat_q, dat_d;
  logic               last_q, last_d;
  logic [1:0]         ch_q, ch_d;
  logic [2:0]         ch_oh;

  logic               in_xfer;
  logic               out_xfer;
  logic [1:0]         in_ch;

  always_comb begin
    ch_oh = 3'b000;
    case (ch_q)
      2'd0:    ch_oh = 3'b001;
      2'd1:    ch_oh = 3'b010;
      default: ch_oh = 3'b100;
    endcase
  end

  assign out_xfer = full_q & (|(ch_oh & o_ready));
  assign in_xfer  = d_valid & d_ready;
  assign in_ch    = (state_q == LOCKED) ? lch_q : ((s == 2'd3) ? 2'd2 : s);

  assign o       = dat_q;
  assign o_last  = last_q;
  assign o_valid = full_q ? ch_oh : 3'b000;
  assign busy    = (state_q == LOCKED);

  // Lock FSM advances only on accepted beats; channel is frozen for the rest of the packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lch_q   <= 2'd0;
    end else if (in_xfer) begin
      case (state_q)
        IDLE: begin
          if (!d_last) begin
            state_q <= LOCKED;
            lch_q   <= in_ch;
          end
        end
        LOCKED: begin
          if (d_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DEMUX3_SKID_EN
  logic               skid_full_q, skid_full_d;
  logic [WIREWIDTH:0] skid_dat_q, skid_dat_d;
  logic               skid_last_q, skid_last_d;
  logic [1:0]         skid_ch_q, skid_ch_d;
  logic               rdy_q;

  assign d_ready = rst_n & rdy_q;

  // Skid only fills while the output register is stalled; it always drains before new input.
  always_comb begin
    full_d      = full_q;
    dat_d       = dat_q;
    last_d      = last_q;
    ch_d        = ch_q;
    skid_full_d = skid_full_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    skid_ch_d   = skid_ch_q;
    if (out_xfer || !full_q) begin
      if (skid_full_q) begin
        full_d      = 1'b1;
        dat_d       = skid_dat_q;
        last_d      = skid_last_q;
        ch_d        = skid_ch_q;
        skid_full_d = 1'b0;
      end else if (in_xfer) begin
        full_d = 1'b1;
        dat_d  = d;
        last_d = d_last;
        ch_d   = in_ch;
      end else begin
        full_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_full_d = 1'b1;
      skid_dat_d  = d;
      skid_last_d = d_last;
      skid_ch_d   = in_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_full_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
      skid_ch_q   <= 2'd0;
      rdy_q       <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
      skid_ch_q   <= skid_ch_d;
      rdy_q       <= !skid_full_d;
    end
  end
`else
  assign d_ready = rst_n & (!full_q | out_xfer);

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    last_d = last_q;
    ch_d   = ch_q;
    if (in_xfer) begin
      full_d = 1'b1;
      dat_d  = d;
      last_d = d_last;
      ch_d   = in_ch;
    end else if (out_xfer) begin
      full_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
      ch_q   <= 2'd0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
      last_q <= last_d;
      ch_q   <= ch_d;
    end
  end

endmodule

// File: tb/tb_demux3.sv
// Bench for demux3: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_demux3;
  localparam int W = 7;
`ifdef DEMUX3_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [1:0]   s;
  logic [W:0]   d;
  logic         d_valid;
  logic         d_last;
  logic         d_ready;
  logic [W:0]   o;
  logic         o_last;
  logic [2:0]   o_valid;
  logic [2:0]   o_ready;
  logic         busy;

  demux3 #(.WIREWIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(d_ready), .o(o), .o_last(o_last), .o_valid(o_valid),
    .o_ready(o_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W:0] dat;
    logic [1:0] ch;
    logic       last;
  } beat_t;

  int    compared = 0;
  int    mismatched = 0;
  bit    mon_en = 1'b0;
  beat_t q[$];
  bit    m_locked = 1'b0;
  logic [1:0] m_ch = 2'd0;
  int    since = 0;

  // Reference model: a FIFO of accepted beats (front = what the output must show) plus packet lock.
  always @(negedge clk) begin
    logic       fire;
    logic       exp_rdy;
    logic [2:0] exp_ov;
    logic [1:0] ch;
    beat_t      b;
    if (mon_en) begin
      fire = (q.size() != 0) && o_ready[q[0].ch];
      if (SKID) exp_rdy = rst_n && (since >= 1) && (q.size() < 2);
      else      exp_rdy = rst_n && ((q.size() == 0) || fire);
      compared++;
      if (d_ready !== exp_rdy) begin
        mismatched++;
        $display("FAIL mon_d_ready t=%0t got=%b exp=%b", $time, d_ready, exp_rdy);
      end
      exp_ov = (q.size() != 0) ? (3'b001 << q[0].ch) : 3'b000;
      compared++;
      if (o_valid !== exp_ov) begin
        mismatched++;
        $display("FAIL mon_o_valid t=%0t got=%b exp=%b", $time, o_valid, exp_ov);
      end
      if (q.size() != 0) begin
        compared++;
        if (o !== q[0].dat || o_last !== q[0].last) begin
          mismatched++;
          $display("FAIL mon_o_data t=%0t got=%h/%b exp=%h/%b", $time, o, o_last, q[0].dat, q[0].last);
        end
      end
      compared++;
      if (busy !== m_locked) begin
        mismatched++;
        $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, m_locked);
      end
      if (fire) void'(q.pop_front());
      if (rst_n && d_valid && d_ready) begin
        ch = m_locked ? m_ch : ((s == 2'd3) ? 2'd2 : s);
        b.dat = d; b.ch = ch; b.last = d_last;
        q.push_back(b);
        if (!m_locked && !d_last) begin
          m_locked = 1'b1;
          m_ch = ch;
        end else if (m_locked && d_last) begin
          m_locked = 1'b0;
        end
      end
      if (!rst_n) begin
        q.delete();
        m_locked = 1'b0;
        since = 0;
      end else begin
        since++;
      end
    end
  end

  task automatic send(input logic [1:0] sv, input logic [W:0] dv, input logic lv);
    int n;
    @(posedge clk); #1;
    s = sv; d = dv; d_last = lv; d_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!d_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!d_ready) begin
      mismatched++;
      $display("FAIL send_timeout d=%h got d_ready=%b exp=1", dv, d_ready);
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d_valid = 1'b0; d_last = 1'b0; s = 2'd0; d = '0; o_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    compared++;
    if (d_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_d_ready_low got=%b exp=0", d_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b000 || o !== '0 || o_last !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs got ov=%b o=%h last=%b busy=%b exp all 0", o_valid, o, o_last, busy);
    end
    compared++;
    if (d_ready !== !SKID) begin
      mismatched++;
      $display("FAIL reset_first_ready got=%b exp=%b", d_ready, !SKID);
    end
  endtask

  task automatic test_single();
    o_ready = 3'b111;
    send(2'd1, 8'h02, 1'b1);
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b010 || o !== 8'h02 || o_last !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_s1 got ov=%b o=%h last=%b busy=%b exp 010/02/1/0", o_valid, o, o_last, busy);
    end
    send(2'd3, 8'h01, 1'b1);
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b100 || o !== 8'h01) begin
      mismatched++;
      $display("FAIL single_s3 got ov=%b o=%h exp 100/01", o_valid, o);
    end
  endtask

  task automatic test_packet();
    logic [1:0] sv [4] = '{2'd0, 2'd2, 2'd2, 2'd2};
    logic       lv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] eov[4] = '{3'b001, 3'b001, 3'b001, 3'b100};
    logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [W:0] dv;
    o_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      dv = (i == 3) ? 8'h04 : 8'(i + 1);
      send(sv[i], dv, lv[i]);
      @(negedge clk);
      compared++;
      if (o_valid !== eov[i] || o !== dv || busy !== eb[i]) begin
        mismatched++;
        $display("FAIL packet_beat%0d got ov=%b o=%h busy=%b exp %b/%h/%b", i, o_valid, o, busy, eov[i], dv, eb[i]);
      end
    end
  endtask

  task automatic test_stall();
    int   acc;
    logic rdy;
    o_ready = 3'b111;
    @(posedge clk); #1;
    o_ready = 3'b000; s = 2'd1; d_last = 1'b1; d_valid = 1'b1; d = 8'hA0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rdy = d_ready;
      if (c == 1) begin
        compared++;
        if (rdy !== SKID) begin
          mismatched++;
          $display("FAIL stall_first_ready got=%b exp=%b", rdy, SKID);
        end
      end
      if (c >= 2) begin
        compared++;
        if (rdy !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_ready_c%0d got=%b exp=0", c, rdy);
        end
      end
      if (c >= 1) begin
        compared++;
        if (o !== 8'hA0 || o_valid !== 3'b010) begin
          mismatched++;
          $display("FAIL stall_hold_c%0d got o=%h ov=%b exp A0/010", c, o, o_valid);
        end
      end
      @(posedge clk); #1;
      if (rdy) begin acc++; d = d + 1'b1; end
    end
    compared++;
    if (acc !== (SKID ? 2 : 1)) begin
      mismatched++;
      $display("FAIL stall_accepted got=%0d exp=%0d", acc, SKID ? 2 : 1);
    end
    o_ready = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy = d_ready;
      @(posedge clk); #1;
      if (rdy) d = d + 1'b1;
    end
    d_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_drain got=%0d pending exp=0", q.size());
    end
  endtask

  task automatic test_mid_reset();
    o_ready = 3'b000;
    send(2'd1, 8'h05, 1'b0);
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b010 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_pre got ov=%b busy=%b exp 010/1", o_valid, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    o_ready = 3'b111;
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b000 || busy !== 1'b0 || o !== '0) begin
      mismatched++;
      $display("FAIL midrst_post got ov=%b busy=%b o=%h exp 000/0/00", o_valid, busy, o);
    end
    send(2'd0, 8'h06, 1'b1);
    @(negedge clk);
    compared++;
    if (o_valid !== 3'b001 || o !== 8'h06) begin
      mismatched++;
      $display("FAIL midrst_next got ov=%b o=%h exp 001/06", o_valid, o);
    end
  endtask

  task automatic test_back_to_back();
    o_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        s = 2'(i % 3); d = 8'(8'h10 + i); d_last = 1'b1; d_valid = 1'b1;
      end else begin
        d_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        compared++;
        if (d_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_ready_%0d got=%b exp=1", i, d_ready);
        end
      end
      if (i >= 1) begin
        compared++;
        if (o_valid !== (3'b001 << ((i - 1) % 3)) || o !== 8'(8'h10 + i - 1)) begin
          mismatched++;
          $display("FAIL b2b_out_%0d got ov=%b o=%h exp %b/%h", i - 1, o_valid, o,
                   3'b001 << ((i - 1) % 3), 8'(8'h10 + i - 1));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      s       = 2'($urandom_range(0, 3));
      d       = 8'($urandom);
      d_last  = ($urandom_range(0, 9) < 3);
      d_valid = ($urandom_range(0, 9) < 7);
      o_ready = 3'($urandom);
    end
    @(posedge clk); #1;
    d_valid = 1'b0; d_last = 1'b0; o_ready = 3'b111;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL random_drain got=%0d pending exp=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
